// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand forwarding, load-use/RAW stall and multi-cycle op tracking
module hazard_forward_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 5,
    parameter int FWD_EN  = 1,
    parameter int LAT_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*IDX_W-1:0]   id_rs,
    input  logic                       id_is_mc,
    input  logic [NUM_SRC*IDX_W-1:0]   ex_rs,
    input  logic [IDX_W-1:0]           ex_rd,
    input  logic                       ex_load_reg,
    input  logic                       ex_is_load,
    input  logic [IDX_W-1:0]           mem_rd,
    input  logic                       mem_load_reg,
    input  logic [IDX_W-1:0]           wb_rd,
    input  logic                       wb_load_reg,
    input  logic                       mc_issue,
    input  logic [IDX_W-1:0]           mc_rd,
    input  logic [LAT_W-1:0]           mc_lat,
    output logic [NUM_SRC*2-1:0]       fwd_sel,
    output logic                       stall,
    output logic                       idex_bubble,
    output logic                       mc_busy,
    output logic                       mc_wb_valid,
    output logic [IDX_W-1:0]           mc_wb_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    mc_state_t        state, state_nxt;
    logic [LAT_W-1:0] count, count_nxt;
    logic [IDX_W-1:0] pend_rd, pend_rd_nxt;
    logic [LAT_W-1:0] issue_cnt;

    logic [NUM_SRC*2-1:0] fwd_raw;
    logic                 load_use;
    logic                 raw_stall;
    logic                 mc_data;
    logic                 stall_raw;

    // A zero latency behaves like one: result is ready on the following cycle.
    assign issue_cnt = (mc_lat == '0) ? '0 : mc_lat - LAT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            pend_rd <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            pend_rd <= pend_rd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        pend_rd_nxt = pend_rd;
        case (state)
            IDLE, DONE: begin
                if (mc_issue) begin
                    pend_rd_nxt = mc_rd;
                    count_nxt   = issue_cnt;
                    state_nxt   = (issue_cnt == '0) ? DONE : BUSY;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            BUSY: begin
                // mc_issue cannot legally arrive here and is ignored.
                if (count > LAT_W'(1)) begin
                    count_nxt = count - LAT_W'(1);
                end else begin
                    count_nxt = '0;
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        fwd_raw   = '0;
        load_use  = 1'b0;
        raw_stall = 1'b0;
        mc_data   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (FWD_EN != 0) begin
                if (mem_load_reg && mem_rd != '0 && mem_rd == ex_rs[i*IDX_W +: IDX_W])
                    fwd_raw[i*2 +: 2] = 2'b01;
                else if (wb_load_reg && wb_rd != '0 && wb_rd == ex_rs[i*IDX_W +: IDX_W])
                    fwd_raw[i*2 +: 2] = 2'b10;
            end
            // A non-zero ID source makes every equality below imply a non-zero rd.
            if (id_rs[i*IDX_W +: IDX_W] != '0) begin
                if (ex_is_load && ex_load_reg && ex_rd == id_rs[i*IDX_W +: IDX_W])
                    load_use = 1'b1;
                if (FWD_EN == 0 &&
                    ((ex_load_reg && ex_rd == id_rs[i*IDX_W +: IDX_W]) ||
                     (mem_load_reg && mem_rd == id_rs[i*IDX_W +: IDX_W])))
                    raw_stall = 1'b1;
                if (state == BUSY && pend_rd == id_rs[i*IDX_W +: IDX_W])
                    mc_data = 1'b1;
            end
        end
    end

    // Dependents are released in DONE since the result lands in the regfile that edge.
    assign stall_raw = load_use | raw_stall | mc_data | (id_is_mc && state == BUSY);

    assign fwd_sel     = rst ? '0 : fwd_raw;
    assign stall       = ~rst & stall_raw;
    assign idex_bubble = ~rst & stall_raw;
    assign mc_busy     = ~rst & (state != IDLE);
    assign mc_wb_valid = ~rst & (state == DONE);
    assign mc_wb_rd    = (!rst && state == DONE) ? pend_rd : '0;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed checks for hazard_forward_ctrl with and without forwarding
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic        id_is_mc;
    logic [9:0]  ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_load_reg;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_load_reg;
    logic [4:0]  wb_rd;
    logic        wb_load_reg;
    logic        mc_issue;
    logic [4:0]  mc_rd;
    logic [5:0]  mc_lat;

    logic [3:0]  fwd_a, fwd_b;
    logic        stall_a, stall_b, bubble_a, bubble_b;
    logic        busy_a, busy_b, wbv_a, wbv_b;
    logic [4:0]  wbrd_a, wbrd_b;

    int n_checks = 0;
    int n_errors = 0;
    logic seen_wbv;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.NUM_SRC(2), .IDX_W(5), .FWD_EN(1), .LAT_W(6)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_is_mc(id_is_mc), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_load_reg(ex_load_reg), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_load_reg(mem_load_reg), .wb_rd(wb_rd),
        .wb_load_reg(wb_load_reg), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat),
        .fwd_sel(fwd_a), .stall(stall_a), .idex_bubble(bubble_a), .mc_busy(busy_a),
        .mc_wb_valid(wbv_a), .mc_wb_rd(wbrd_a)
    );

    hazard_forward_ctrl #(.NUM_SRC(2), .IDX_W(5), .FWD_EN(0), .LAT_W(6)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_is_mc(id_is_mc), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_load_reg(ex_load_reg), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_load_reg(mem_load_reg), .wb_rd(wb_rd),
        .wb_load_reg(wb_load_reg), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat),
        .fwd_sel(fwd_b), .stall(stall_b), .idex_bubble(bubble_b), .mc_busy(busy_b),
        .mc_wb_valid(wbv_b), .mc_wb_rd(wbrd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_is_mc = 0; ex_rs = '0; ex_rd = '0; ex_load_reg = 0; ex_is_load = 0;
        mem_rd = '0; mem_load_reg = 0; wb_rd = '0; wb_load_reg = 0;
        mc_issue = 0; mc_rd = '0; mc_lat = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Expected per-cycle mc behaviour for lat=4, rd=7, id_rs[0]=7 held from the cycle after issue.
    logic exp_busy4  [5] = '{1, 1, 1, 1, 0};
    logic exp_stall4 [5] = '{1, 1, 1, 0, 0};
    logic exp_valid4 [5] = '{0, 0, 0, 1, 0};

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Hazards and forwarding hits present while in reset must be masked.
        ex_rs = {5'd3, 5'd3}; mem_rd = 5'd3; mem_load_reg = 1;
        ex_rd = 5'd5; ex_is_load = 1; ex_load_reg = 1; id_rs = {5'd5, 5'd1};
        mid();
        check_eq("rst_fwd",    fwd_a,    4'b0000);
        check_eq("rst_stall",  stall_a,  1'b0);
        check_eq("rst_bubble", bubble_a, 1'b0);
        check_eq("rst_busy",   busy_a,   1'b0);
        check_eq("rst_wbv",    wbv_a,    1'b0);
        check_eq("rst_wbrd",   wbrd_a,   5'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_fwd",   fwd_a,   4'b0101);
        check_eq("post_rst_stall", stall_a, 1'b1);

        // Forwarding priority and x0 handling
        step(); clear_inputs();
        ex_rs = {5'd3, 5'd3}; mem_rd = 5'd3; mem_load_reg = 1; wb_rd = 5'd3; wb_load_reg = 1;
        mid();
        check_eq("fwd_mem_over_wb", fwd_a, 4'b0101);
        check_eq("fwd_off_b1",      fwd_b, 4'b0000);
        mem_load_reg = 0; #1;
        check_eq("fwd_wb", fwd_a, 4'b1010);
        ex_rs = {5'd3, 5'd4}; wb_rd = 5'd4; mem_rd = 5'd3; mem_load_reg = 1; #1;
        check_eq("fwd_mixed",  fwd_a, 4'b0110);
        check_eq("fwd_off_b2", fwd_b, 4'b0000);
        ex_rs = '0; mem_rd = '0; wb_rd = '0; #1;
        check_eq("fwd_x0", fwd_a, 4'b0000);

        // Load-use for one cycle, then the bubble occupies EX
        step(); clear_inputs();
        ex_rd = 5'd5; ex_is_load = 1; ex_load_reg = 1; id_rs = {5'd5, 5'd1};
        mid();
        check_eq("lu_stall",  stall_a,  1'b1);
        check_eq("lu_bubble", bubble_a, 1'b1);
        step();
        ex_rd = '0; ex_is_load = 0; ex_load_reg = 0;
        mid();
        check_eq("lu_released", stall_a, 1'b0);
        ex_is_load = 1; ex_load_reg = 1; id_rs = {5'd0, 5'd1}; #1;
        check_eq("lu_x0", stall_a, 1'b0);
        ex_is_load = 0; ex_rd = 5'd6; id_rs = {5'd6, 5'd0}; #1;
        check_eq("alu_raw_fwd",   stall_a, 1'b0);
        check_eq("alu_raw_nofwd", stall_b, 1'b1);

        // No-forwarding build stalls on a live MEM destination
        step(); clear_inputs();
        mem_rd = 5'd9; mem_load_reg = 1; id_rs = {5'd0, 5'd9}; ex_rs = {5'd9, 5'd9};
        mid();
        check_eq("nofwd_mem_stall",  stall_b,  1'b1);
        check_eq("nofwd_mem_bubble", bubble_b, 1'b1);
        check_eq("fwd_mem_nostall",  stall_a,  1'b0);
        check_eq("nofwd_fwd_zero",   fwd_b,    4'b0000);
        check_eq("fwd_mem_sel",      fwd_a,    4'b0101);

        // Multi-cycle op, lat=4, dependent instruction waiting in ID
        step(); clear_inputs();
        mc_issue = 1; mc_rd = 5'd7; mc_lat = 6'd4;
        mid();
        check_eq("mc4_issue_idle", busy_a, 1'b0);
        step();
        mc_issue = 0; id_rs = {5'd0, 5'd7};
        for (int c = 0; c < 5; c++) begin
            mid();
            check_eq($sformatf("mc4_busy_c%0d", c + 1),  busy_a,  exp_busy4[c]);
            check_eq($sformatf("mc4_stall_c%0d", c + 1), stall_a, exp_stall4[c]);
            check_eq($sformatf("mc4_valid_c%0d", c + 1), wbv_a,   exp_valid4[c]);
            if (exp_valid4[c]) check_eq("mc4_wb_rd", wbrd_a, 5'd7);
            step();
        end

        // Zero latency, back-to-back issue in DONE, structural stall
        clear_inputs();
        mc_issue = 1; mc_rd = 5'd12; mc_lat = 6'd0;
        step();
        mc_issue = 0;
        mid();
        check_eq("mc0_done_valid", wbv_a,  1'b1);
        check_eq("mc0_done_rd",    wbrd_a, 5'd12);
        mc_issue = 1; mc_rd = 5'd13; mc_lat = 6'd3;
        step();
        mc_issue = 0; id_is_mc = 1;
        mid();
        check_eq("b2b_busy",       busy_a,  1'b1);
        check_eq("b2b_valid",      wbv_a,   1'b0);
        check_eq("struct_stall_1", stall_a, 1'b1);
        step(); mid();
        check_eq("struct_stall_2", stall_a, 1'b1);
        step(); mid();
        check_eq("b2b_done_valid", wbv_a,   1'b1);
        check_eq("b2b_done_rd",    wbrd_a,  5'd13);
        check_eq("done_no_stall",  stall_a, 1'b0);
        step(); mid();
        check_eq("b2b_idle", busy_a, 1'b0);

        // Asynchronous reset while BUSY discards the pending result
        step(); clear_inputs();
        mc_issue = 1; mc_rd = 5'd20; mc_lat = 6'd10;
        step();
        mc_issue = 0; id_rs = {5'd0, 5'd20};
        step(); step(); step();
        #2;
        check_eq("pre_rst_busy",  busy_a,  1'b1);
        check_eq("pre_rst_stall", stall_a, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy",  busy_a,  1'b0);
        check_eq("midrst_stall", stall_a, 1'b0);
        check_eq("midrst_wbv",   wbv_a,   1'b0);
        mid();
        rst = 1'b0;
        seen_wbv = 1'b0;
        for (int c = 0; c < 14; c++) begin
            mid();
            if (wbv_a || busy_a) seen_wbv = 1'b1;
            step();
        end
        check_eq("no_wb_after_rst", seen_wbv, 1'b0);
        check_eq("no_stall_after_rst", stall_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
